s_mac_seq_block: RTL and testbench

S_MAC_SEQ_BLOCK -- requirements
Module: s_mac_seq_block

---
 rtl/s_mac_seq_block.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_s_mac_seq_block.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_mac_seq_block.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : s_mac_seq_block                                              |
// | Description : Bit-serial (bit-plane) SIMD multiply-accumulate engine.      |
// |               Every accepted beat carries one activation bit-plane and     |
// |               one weight bit-plane across M lanes. The beat adds           |
// |               popcount(act & wei) << (i+j) to the accumulator of channel c,|
// |               with the sign set to give two's-complement operands. After   |
// |               the last beat of a job, the NCH accumulators are shifted,    |
// |               quantised and streamed out as channels 0..NCH-1.             |
// |                                                                            |
// | Ports       : clk, rst_n       clock, asynchronous active-low reset        |
// |               start            job request, sampled in IDLE only           |
// |               pa_bits/pw_bits  activation / weight precision (clamped)     |
// |               n_groups         term groups per job (clamped to 1..MNO)     |
// |               qshift           arithmetic right shift before quantising    |
// |               in_valid/ready   act/wei bit-plane beat handshake            |
// |               act, wei         M-lane bit-planes                           |
// |               out_valid/ready  result handshake                            |
// |               out_data, out_ch quantised result and its channel index      |
// |               busy             high whenever the engine is not IDLE       |
// |                                                                            |
// | Build macro : SMAC_RELU_EN     defined   -> ReLU + unsigned saturation     |
// |                                undefined -> signed saturation             |
// |                                                                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module s_mac_seq_block #(
  parameter  int M      = 16,
  parameter  int PA_MAX = 8,
  parameter  int PW_MAX = 8,
  parameter  int NCH    = 4,
  parameter  int MNO    = 288,
  localparam int ACC_W  = $clog2(M) + PA_MAX + PW_MAX + $clog2(MNO) + 1,
  localparam int PAB_W  = $clog2(PA_MAX) + 1,
  localparam int PWB_W  = $clog2(PW_MAX) + 1,
  localparam int NG_W   = $clog2(MNO) + 1,
  localparam int QS_W   = $clog2(ACC_W),
  localparam int CH_W   = $clog2(NCH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PAB_W-1:0]  pa_bits,
  input  logic [PWB_W-1:0]  pw_bits,
  input  logic [NG_W-1:0]   n_groups,
  input  logic [QS_W-1:0]   qshift,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [M-1:0]      act,
  input  logic [M-1:0]      wei,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PA_MAX-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              busy
);

  localparam int POP_W = $clog2(M) + 1;
  localparam int SH_W  = $clog2(PA_MAX + PW_MAX) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state;

  // Latched job configuration (already clamped when latched)
  logic [PAB_W-1:0] pa_q;
  logic [PWB_W-1:0] pw_q;
  logic [NG_W-1:0]  ng_q;
  logic [QS_W-1:0]  qs_q;

  // Beat position counters: g (outer) -> c -> j -> i (inner)
  logic [PAB_W-1:0] i_cnt;
  logic [PWB_W-1:0] j_cnt;
  logic [CH_W-1:0]  c_cnt;
  logic [NG_W-1:0]  g_cnt;

  logic signed [ACC_W-1:0] acc [NCH];

  // ---------------------------------------------------------------------------
  // Configuration clamping
  // ---------------------------------------------------------------------------
  logic [PAB_W-1:0] pa_clamp;
  logic [PWB_W-1:0] pw_clamp;
  logic [NG_W-1:0]  ng_clamp;

  always_comb begin
    pa_clamp = pa_bits;
    if (pa_bits == '0 || pa_bits > PAB_W'(PA_MAX)) pa_clamp = PAB_W'(PA_MAX);
    pw_clamp = pw_bits;
    if (pw_bits == '0 || pw_bits > PWB_W'(PW_MAX)) pw_clamp = PWB_W'(PW_MAX);
    ng_clamp = n_groups;
    if (n_groups == '0)              ng_clamp = NG_W'(1);
    else if (n_groups > NG_W'(MNO))  ng_clamp = NG_W'(MNO);
  end

  // ---------------------------------------------------------------------------
  // Beat datapath
  // ---------------------------------------------------------------------------
  logic [POP_W-1:0]        pop;
  logic [SH_W-1:0]         shamt;
  logic                    i_last, j_last, c_last, g_last;
  logic                    neg;
  logic                    accept;
  logic signed [ACC_W-1:0] mag;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] acc_cur;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc0_post;

  always_comb begin
    pop = '0;
    for (int k = 0; k < M; k++) begin
      pop = pop + POP_W'(act[k] & wei[k]);
    end
  end

  assign i_last = (i_cnt == pa_q - PAB_W'(1));
  assign j_last = (j_cnt == pw_q - PWB_W'(1));
  assign c_last = (c_cnt == CH_W'(NCH - 1));
  assign g_last = (g_cnt == ng_q - NG_W'(1));
  assign accept = (state == S_ACC) && in_valid;

  // Exactly one operand bit at its sign position gives a negative weight
  // in the two's-complement expansion of the product.
  assign neg   = i_last ^ j_last;
  assign shamt = SH_W'(i_cnt) + SH_W'(j_cnt);
  assign mag   = ACC_W'(pop) << shamt;
  assign term  = neg ? -mag : mag;

  always_comb begin
    acc_cur = '0;
    for (int k = 0; k < NCH; k++) begin
      if (c_cnt == CH_W'(k)) acc_cur = acc[k];
    end
  end

  assign acc_sum = acc_cur + term;

  // Channel 0 value as it will be after the current beat; needed when the
  // final beat itself targets channel 0 (NCH == 1).
  assign acc0_post = (c_cnt == '0) ? acc_sum : acc[0];

  // ---------------------------------------------------------------------------
  // Output channel selection
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0]         nxt_ch;
  logic signed [ACC_W-1:0] acc_nxt;

  assign nxt_ch = out_ch + CH_W'(1);

  always_comb begin
    acc_nxt = '0;
    for (int k = 0; k < NCH; k++) begin
      if (nxt_ch == CH_W'(k)) acc_nxt = acc[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Quantisation
  // ---------------------------------------------------------------------------
`ifdef SMAC_RELU_EN
  localparam logic signed [ACC_W-1:0] Q_HI = (ACC_W'(1) <<< PA_MAX) - ACC_W'(1);

  function automatic logic [PA_MAX-1:0] quant(
    input logic signed [ACC_W-1:0] v,
    input logic [QS_W-1:0]         sh
  );
    logic signed [ACC_W-1:0] s;
    s = v >>> sh;
    if (s < 0)         quant = '0;
    else if (s > Q_HI) quant = '1;
    else               quant = s[PA_MAX-1:0];
  endfunction
`else
  localparam logic signed [ACC_W-1:0] Q_HI = (ACC_W'(1) <<< (PA_MAX - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] Q_LO = -(ACC_W'(1) <<< (PA_MAX - 1));

  function automatic logic [PA_MAX-1:0] quant(
    input logic signed [ACC_W-1:0] v,
    input logic [QS_W-1:0]         sh
  );
    logic signed [ACC_W-1:0] s;
    s = v >>> sh;
    if (s > Q_HI)      quant = {1'b0, {(PA_MAX-1){1'b1}}};
    else if (s < Q_LO) quant = {1'b1, {(PA_MAX-1){1'b0}}};
    else               quant = s[PA_MAX-1:0];
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered result outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pa_q      <= '0;
      pw_q      <= '0;
      ng_q      <= '0;
      qs_q      <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      c_cnt     <= '0;
      g_cnt     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pa_q  <= pa_clamp;
            pw_q  <= pw_clamp;
            ng_q  <= ng_clamp;
            qs_q  <= qshift;
            i_cnt <= '0;
            j_cnt <= '0;
            c_cnt <= '0;
            g_cnt <= '0;
            state <= S_ACC;
          end
        end

        S_ACC: begin
          if (accept) begin
            if (!i_last) begin
              i_cnt <= i_cnt + PAB_W'(1);
            end else begin
              i_cnt <= '0;
              if (!j_last) begin
                j_cnt <= j_cnt + PWB_W'(1);
              end else begin
                j_cnt <= '0;
                if (!c_last) begin
                  c_cnt <= c_cnt + CH_W'(1);
                end else begin
                  c_cnt <= '0;
                  if (!g_last) begin
                    g_cnt <= g_cnt + NG_W'(1);
                  end else begin
                    g_cnt     <= '0;
                    state     <= S_OUT;
                    out_valid <= 1'b1;
                    out_ch    <= '0;
                    out_data  <= quant(acc0_post, qs_q);
                  end
                end
              end
            end
          end
        end

        S_OUT: begin
          // out_valid is held high for the whole OUT state
          if (out_ready) begin
            if (out_ch == CH_W'(NCH - 1)) begin
              out_valid <= 1'b0;
              out_ch    <= '0;
              out_data  <= '0;
              state     <= S_IDLE;
            end else begin
              out_ch    <= nxt_ch;
              out_data  <= quant(acc_nxt, qs_q);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulators: cleared on job start, updated on the accepting edge
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) acc[k] <= '0;
    end else if (state == S_IDLE && start) begin
      for (int k = 0; k < NCH; k++) acc[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < NCH; k++) begin
        if (c_cnt == CH_W'(k)) acc[k] <= acc_sum;
      end
    end
  end

  // Decoded straight from the state register so they drop with reset
  assign in_ready = (state == S_ACC);
  assign busy     = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_s_mac_seq_block.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_s_mac_seq_block                                           |
// | Description : Self-checking bench for s_mac_seq_block. Operand values are  |
// |               chosen as signed integers; the expected result per channel   |
// |               is the plain sum of products, shifted and quantised. The     |
// |               bit-planes driven into the DUT are sliced from those values. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_s_mac_seq_block;

  localparam int M      = 16;
  localparam int PA_MAX = 8;
  localparam int PW_MAX = 8;
  localparam int NCH    = 4;
  localparam int MNO    = 288;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  pa_bits = '0;
  logic [3:0]  pw_bits = '0;
  logic [9:0]  n_groups = '0;
  logic [4:0]  qshift = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] act = '0;
  logic [15:0] wei = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        busy;

  s_mac_seq_block #(
    .M(M), .PA_MAX(PA_MAX), .PW_MAX(PW_MAX), .NCH(NCH), .MNO(MNO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pa_bits(pa_bits), .pw_bits(pw_bits), .n_groups(n_groups), .qshift(qshift),
    .in_valid(in_valid), .in_ready(in_ready), .act(act), .wei(wei),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Operand values per group / channel / lane
  int av [MNO][NCH][M];
  int wv [MNO][NCH][M];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference quantiser on the exact integer sum
  function automatic logic [7:0] model_q(input longint v, input int qs);
    longint s;
    s = v >>> qs;
`ifdef SMAC_RELU_EN
    if (s < 0)        s = 0;
    else if (s > 255) s = 255;
`else
    if (s > 127)       s = 127;
    else if (s < -128) s = -128;
`endif
    return s[7:0];
  endfunction

  task automatic clear_vals();
    for (int g = 0; g < MNO; g++)
      for (int c = 0; c < NCH; c++)
        for (int l = 0; l < M; l++) begin
          av[g][c][l] = 0;
          wv[g][c][l] = 0;
        end
  endtask

  // stall_ch < 0 : no back-pressure; inject : stray start in ACC, in_valid in OUT
  task automatic run_job(input int pa_in, input int pw_in, input int ng_in, input int qs,
                         input int stall_ch, input bit inject, input bit rnd);
    int pa, pw, ng, cnt;
    longint sum [NCH];
    logic [7:0] expq [NCH];
    pa = (pa_in == 0 || pa_in > PA_MAX) ? PA_MAX : pa_in;
    pw = (pw_in == 0 || pw_in > PW_MAX) ? PW_MAX : pw_in;
    ng = (ng_in == 0) ? 1 : (ng_in > MNO) ? MNO : ng_in;
    if (rnd) begin
      clear_vals();
      for (int g = 0; g < ng; g++)
        for (int c = 0; c < NCH; c++)
          for (int l = 0; l < M; l++) begin
            av[g][c][l] = int'($urandom_range(0, (1 << pa) - 1)) - (1 << (pa - 1));
            wv[g][c][l] = int'($urandom_range(0, (1 << pw) - 1)) - (1 << (pw - 1));
          end
    end
    for (int c = 0; c < NCH; c++) begin
      sum[c] = 0;
      for (int g = 0; g < ng; g++)
        for (int l = 0; l < M; l++)
          sum[c] += longint'(av[g][c][l]) * longint'(wv[g][c][l]);
      expq[c] = model_q(sum[c], qs);
    end

    pa_bits  = 4'(pa_in);
    pw_bits  = 4'(pw_in);
    n_groups = 10'(ng_in);
    qshift   = 5'(qs);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start", busy, 1);
    check("in_ready_acc", in_ready, 1);

    for (int g = 0; g < ng; g++)
      for (int c = 0; c < NCH; c++)
        for (int j = 0; j < pw; j++)
          for (int i = 0; i < pa; i++) begin
            if ($urandom_range(0, 3) == 0) begin
              in_valid = 1'b0;
              act = 16'($urandom);
              wei = 16'($urandom);
              @(posedge clk); #1;
            end
            for (int l = 0; l < M; l++) begin
              act[l] = 1'((av[g][c][l] >>> i) & 1);
              wei[l] = 1'((wv[g][c][l] >>> j) & 1);
            end
            in_valid = 1'b1;
            if (inject && g == 0 && c == 0 && j == 0 && i == 1) begin
              start    = 1'b1;
              pa_bits  = 4'd1;
              n_groups = 10'd5;
            end
            @(posedge clk); #1;
            start = 1'b0;
          end
    in_valid = 1'b0;
    act = '0;
    wei = '0;
    check("out_valid_first", out_valid, 1);

    out_ready = 1'b1;
    if (inject) begin
      in_valid = 1'b1;
      act = '1;
      wei = '1;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 20) begin
        @(posedge clk); #1;
        cnt++;
      end
      check("out_valid", out_valid, 1);
      check("out_ch", out_ch, ch);
      check("out_data", out_data, expq[ch]);
      if (inject) check("in_ready_out", in_ready, 0);
      if (ch == stall_ch) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          check("hold_valid", out_valid, 1);
          check("hold_ch", out_ch, ch);
          check("hold_data", out_data, expq[ch]);
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    act = '0;
    wei = '0;
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    check("no_extra_job", {out_valid, busy}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ch0 = 1*1 per lane -> 16, other channels zero
    clear_vals();
    for (int l = 0; l < M; l++) begin av[0][0][l] = 1; wv[0][0][l] = 1; end
    run_job(2, 2, 1, 0, -1, 1'b0, 1'b0);

    // ch0 act = -1 per lane -> -16
    for (int l = 0; l < M; l++) av[0][0][l] = -1;
    run_job(2, 2, 1, 0, -1, 1'b0, 1'b0);

    // 5*4*16 = 320, then qshift = 2 -> 80
    clear_vals();
    for (int l = 0; l < M; l++) begin av[0][0][l] = 5; wv[0][0][l] = 4; end
    run_job(8, 8, 1, 0, -1, 1'b0, 1'b0);
    run_job(8, 8, 1, 2, -1, 1'b0, 1'b0);

    // Back-pressure on channel 1
    run_job(8, 8, 3, 4, 1, 1'b0, 1'b1);

    // Stray start during ACC and in_valid during OUT
    run_job(3, 5, 2, 0, -1, 1'b1, 1'b1);

    // Precision / group clamps: 0 and out-of-range values
    run_job(0, 12, 0, 2, -1, 1'b0, 1'b1);
    run_job(1, 1, 1023, 3, 2, 1'b0, 1'b1);

    // Reset in the middle of ACC
    pa_bits  = 4'd8;
    pw_bits  = 4'd8;
    n_groups = 10'd2;
    qshift   = 5'd0;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) begin
      in_valid = 1'b1;
      act = 16'($urandom);
      wei = 16'($urandom);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #2;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_ch", out_ch, 0);
    in_valid = 1'b0;
    act = '0;
    wei = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(4, 4, 2, 3, -1, 1'b0, 1'b1);

    // Random configurations
    for (int k = 0; k < 3; k++) begin
      run_job(int'($urandom_range(1, 8)), int'($urandom_range(1, 8)),
              int'($urandom_range(1, 3)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 4)) - 1, 1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
